// File: rtl/uart_byte_tx_if.sv
// Byte-request and serial-line signal bundle between a UART transmitter and its feeder.
// The master side issues requests and reads status; the slave (transmitter) drives the line.
interface uart_byte_tx_if;
  logic [2:0] Baud_set;
  logic [7:0] Data;
  logic       send_en;
  logic       uart_tx;
  logic       tx_busy;
  logic       tx_done;

  modport master (
    output Baud_set, Data, send_en,
    input  uart_tx, tx_busy, tx_done
  );

  modport slave (
    input  Baud_set, Data, send_en,
    output uart_tx, tx_busy, tx_done
  );
endinterface

// File: rtl/uart_byte_tx.sv
// 8N1 UART transmitter (optional parity / second stop bit); line low one cycle after acceptance.
// Requests while busy are dropped, not queued; tx_done pulses one cycle after the last stop bit.
module uart_byte_tx #(
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic          sysclk,
  input  logic          rst,
  uart_byte_tx_if.slave tx_if
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic LAST_STOP = (STOP_BITS == 2);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [13:0] r_cnt;
  logic [13:0] r_n;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic        r_parity;
  logic        r_stop_idx;
  logic        r_tx;
  logic        r_busy;
  logic        r_done;
  logic        w_bit_end;
  logic        w_tx_nxt;
  logic        w_busy_nxt;
  logic        w_done_nxt;

  function automatic logic [13:0] baud_to_n(input logic [2:0] b);
    logic [13:0] n;
    case (b)
      3'd1:    n = 14'd5208;
      3'd2:    n = 14'd10416;
      default: n = 14'd434;
    endcase
    return n;
  endfunction

  assign w_bit_end = (r_cnt == r_n - 14'd1);

  // w_tx_nxt is the line value for the coming cycle, so uart_tx stays a plain flop.
  always_comb begin
    w_state_nxt = r_state;
    w_tx_nxt    = 1'b1;
    w_busy_nxt  = 1'b1;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (tx_if.send_en) begin
          w_state_nxt = START;
          w_tx_nxt    = 1'b0;
        end else begin
          w_busy_nxt  = 1'b0;
        end
      end
      START: begin
        w_tx_nxt = 1'b0;
        if (w_bit_end) begin
          w_state_nxt = DATA;
          w_tx_nxt    = r_shift[0];
        end
      end
      DATA: begin
        w_tx_nxt = r_shift[0];
        if (w_bit_end) begin
          if (r_bit_idx == 3'd7) begin
            if (PARITY_EN) begin
              w_state_nxt = PARITY;
              w_tx_nxt    = r_parity;
            end else begin
              w_state_nxt = STOP;
              w_tx_nxt    = 1'b1;
            end
          end else begin
            w_tx_nxt = r_shift[1];
          end
        end
      end
      PARITY: begin
        w_tx_nxt = r_parity;
        if (w_bit_end) begin
          w_state_nxt = STOP;
          w_tx_nxt    = 1'b1;
        end
      end
      STOP: begin
        if (w_bit_end && (r_stop_idx == LAST_STOP)) begin
          w_state_nxt = IDLE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cnt      <= 14'd0;
      r_n        <= 14'd0;
      r_bit_idx  <= 3'd0;
      r_shift    <= 8'd0;
      r_parity   <= 1'b0;
      r_stop_idx <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      if (r_state == IDLE) begin
        r_cnt      <= 14'd0;
        r_bit_idx  <= 3'd0;
        r_stop_idx <= 1'b0;
        if (tx_if.send_en) begin
          r_shift  <= tx_if.Data;
          r_n      <= baud_to_n(tx_if.Baud_set);
          r_parity <= (^tx_if.Data) ^ PARITY_ODD;
        end
      end else begin
        r_cnt <= w_bit_end ? 14'd0 : r_cnt + 14'd1;
        if (w_bit_end && (r_state == DATA)) begin
          r_bit_idx <= r_bit_idx + 3'd1;
          r_shift   <= {1'b0, r_shift[7:1]};
        end
        if (w_bit_end && (r_state == STOP)) begin
          r_stop_idx <= 1'b1;
        end
      end
    end
  end

  assign tx_if.uart_tx = r_tx;
  assign tx_if.tx_busy = r_busy;
  assign tx_if.tx_done = r_done;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Bench for uart_byte_tx: line/busy/done activity is logged as timestamped changes and each
// frame is compared with a waveform computed from the frame rules; stamps are spec cycle numbers.
module tb_uart_byte_tx;
  logic   sysclk = 1'b0;
  logic   rst    = 1'b0;
  logic   rst_p  = 1'b0;
  longint cyc    = 0;
  int     n_tests = 0;
  int     n_fail  = 0;

  always #10 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  uart_byte_tx_if if0();
  uart_byte_tx_if ifp1();
  uart_byte_tx_if ifp2();
  uart_byte_tx_if ifp3();

  uart_byte_tx dut0 (.sysclk(sysclk), .rst(rst), .tx_if(if0));
  uart_byte_tx #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(1))
    dut_even (.sysclk(sysclk), .rst(rst_p), .tx_if(ifp1));
  uart_byte_tx #(.PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(1))
    dut_odd (.sysclk(sysclk), .rst(rst_p), .tx_if(ifp2));
  uart_byte_tx #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(2))
    dut_stop2 (.sysclk(sysclk), .rst(rst_p), .tx_if(ifp3));

  typedef struct { longint t; logic v; } ev_t;
  ev_t    tx_log   [4][$];
  ev_t    bz_log   [4][$];
  longint done_log [4][$];
  logic   last_tx  [4];
  logic   last_bz  [4];
  bit     seen     [4];

  task automatic log_sample(input int i, input logic tx, input logic bz, input logic dn);
    if (!seen[i] || tx != last_tx[i]) begin
      tx_log[i].push_back('{cyc + 1, tx});
      last_tx[i] = tx;
    end
    if (!seen[i] || bz != last_bz[i]) begin
      bz_log[i].push_back('{cyc + 1, bz});
      last_bz[i] = bz;
    end
    if (dn) done_log[i].push_back(cyc + 1);
    seen[i] = 1'b1;
  endtask

  always @(negedge sysclk) begin
    log_sample(0, if0.uart_tx,  if0.tx_busy,  if0.tx_done);
    log_sample(1, ifp1.uart_tx, ifp1.tx_busy, ifp1.tx_done);
    log_sample(2, ifp2.uart_tx, ifp2.tx_busy, ifp2.tx_done);
    log_sample(3, ifp3.uart_tx, ifp3.tx_busy, ifp3.tx_done);
  end

  function automatic logic val_at(input bit bz, input int i, input longint c);
    logic v;
    int   n;
    ev_t  e;
    v = 1'bx;
    n = bz ? bz_log[i].size() : tx_log[i].size();
    for (int k = 0; k < n; k++) begin
      e = bz ? bz_log[i][k] : tx_log[i][k];
      if (e.t <= c) v = e.v;
    end
    return v;
  endfunction

  function automatic int changes_in(input bit bz, input int i, input longint a, input longint b);
    int  cnt;
    int  n;
    ev_t e;
    cnt = 0;
    n = bz ? bz_log[i].size() : tx_log[i].size();
    for (int k = 0; k < n; k++) begin
      e = bz ? bz_log[i][k] : tx_log[i][k];
      if (e.t >= a && e.t <= b) cnt++;
    end
    return cnt;
  endfunction

  function automatic longint first_done_after(input int i, input longint a);
    for (int k = 0; k < done_log[i].size(); k++)
      if (done_log[i][k] > a) return done_log[i][k];
    return -1;
  endfunction

  function automatic int dones_in(input int i, input longint a, input longint b);
    int cnt;
    cnt = 0;
    for (int k = 0; k < done_log[i].size(); k++)
      if (done_log[i][k] >= a && done_log[i][k] <= b) cnt++;
    return cnt;
  endfunction

  function automatic longint n_of(input logic [2:0] b);
    if (b == 3'd1) return 5208;
    if (b == 3'd2) return 10416;
    return 434;
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step_to(input longint c);
    while (cyc < c) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  // Expected frame: start 0, data LSB first, optional parity, stop bit(s) high; every bit n cycles.
  task automatic check_frame(input string tag, input int i, input longint t, input logic [7:0] d,
                             input longint n, input bit pen, input bit podd, input int stops);
    logic       bits [12];
    logic [7:0] rx;
    int         f;
    int         errs;
    longint     first;
    longint     last;
    for (int k = 0; k < 12; k++) bits[k] = 1'b1;
    bits[0] = 1'b0;
    for (int k = 0; k < 8; k++) bits[k + 1] = d[k];
    if (pen) bits[9] = (^d) ^ podd;
    f = 9 + int'(pen) + stops;
    errs = (val_at(0, i, t) !== 1'b1) ? 1 : 0;
    for (int k = 0; k < f; k++) begin
      first = t + 1 + k * n;
      last  = t + (k + 1) * n;
      if (val_at(0, i, first) !== bits[k]) errs++;
      errs += changes_in(0, i, first + 1, last);
    end
    chk({tag, " line"}, errs, 0);
    for (int k = 0; k < 8; k++) rx[k] = val_at(0, i, t + 1 + (k + 1) * n + n / 2);
    chk({tag, " rx byte"}, rx, d);
    errs = changes_in(1, i, t + 2, t + f * n);
    if (val_at(1, i, t + 1) !== 1'b1) errs++;
    if (val_at(1, i, t + f * n + 1) !== 1'b0) errs++;
    chk({tag, " busy"}, errs, 0);
    chk({tag, " done at"}, first_done_after(i, t), t + f * n + 1);
    chk({tag, " done width"}, dones_in(i, t + f * n + 2, t + f * n + 2), 0);
    chk({tag, " idle after"}, val_at(0, i, t + f * n + 1), 1);
  endtask

  task automatic drive_p(input logic en);
    ifp1.send_en = en;
    ifp2.send_en = en;
    ifp3.send_en = en;
  endtask

  initial begin
    longint     t;
    longint     t2;
    longint     tp;
    longint     rel;
    logic [7:0] d;
    logic [7:0] d2;
    logic [2:0] b;

    if0.Data = 8'h00;  if0.Baud_set = 3'd0;  if0.send_en = 1'b0;
    ifp1.Data = 8'h07; ifp1.Baud_set = 3'd1;
    ifp2.Data = 8'h07; ifp2.Baud_set = 3'd1;
    ifp3.Data = 8'h07; ifp3.Baud_set = 3'd1;
    drive_p(1'b0);

    for (int k = 0; k < 5; k++) begin
      @(posedge sysclk);
      #1;
      chk("reset tx", if0.uart_tx, 1);
      chk("reset busy", if0.tx_busy, 0);
      chk("reset done", if0.tx_done, 0);
    end
    rst = 1'b1;
    rst_p = 1'b1;
    rel = cyc;
    step_to(rel + 20);
    chk("idle tx", if0.uart_tx, 1);
    chk("idle busy", if0.tx_busy, 0);
    chk("idle done", if0.tx_done, 0);
    chk("idle quiet", changes_in(0, 0, rel + 1, cyc) + changes_in(1, 0, rel + 1, cyc), 0);

    // Basic frame on dut0; the three parity variants start at the same edge and run alongside.
    if0.Data = 8'h55; if0.Baud_set = 3'd0; if0.send_en = 1'b1;
    drive_p(1'b1);
    t = cyc + 1;
    tp = t;
    step_to(t);
    if0.send_en = 1'b0;
    drive_p(1'b0);
    step_to(t + 4341 + 10);
    check_frame("basic", 0, t, 8'h55, 434, 1'b0, 1'b0, 1);
    chk("basic done offset", first_done_after(0, t) - t, 4341);

    if0.Data = 8'h3C; if0.Baud_set = 3'd0; if0.send_en = 1'b1;
    t = cyc + 1;
    step_to(t);
    if0.send_en = 1'b0;
    step_to(t + 499);
    if0.Data = 8'hFF; if0.Baud_set = 3'd1;
    step_to(t + 999);
    if0.send_en = 1'b1;
    step_to(t + 1000);
    if0.send_en = 1'b0;
    step_to(t + 4341 + 500);
    check_frame("ignored", 0, t, 8'h3C, 434, 1'b0, 1'b0, 1);
    chk("ignored done count", dones_in(0, t + 1, cyc), 1);
    chk("ignored line quiet", changes_in(0, 0, t + 4342, cyc), 0);

    if0.Data = 8'hA5; if0.Baud_set = 3'd0; if0.send_en = 1'b1;
    t = cyc + 1;
    step_to(t);
    if0.Data = 8'h5A;
    step_to(t + 4341 + 50);
    if0.send_en = 1'b0;
    step_to(t + 8682 + 10);
    check_frame("b2b first", 0, t, 8'hA5, 434, 1'b0, 1'b0, 1);
    check_frame("b2b second", 0, t + 4341, 8'h5A, 434, 1'b0, 1'b0, 1);
    chk("b2b second start", val_at(0, 0, t + 4342), 0);
    chk("b2b done spacing", first_done_after(0, t + 4341) - first_done_after(0, t), 4341);

    d = 8'($urandom);
    if0.Data = d; if0.send_en = 1'b1;
    t = cyc + 1;
    step_to(t);
    if0.send_en = 1'b0;
    step_to(t + 1999);
    rst = 1'b0;
    step_to(t + 2000);
    rst = 1'b1;
    chk("midrst tx", if0.uart_tx, 1);
    chk("midrst busy", if0.tx_busy, 0);
    step_to(t + 2009);
    d2 = 8'($urandom);
    if0.Data = d2; if0.send_en = 1'b1;
    t2 = cyc + 1;
    step_to(t2);
    if0.send_en = 1'b0;
    step_to(t2 + 4341 + 10);
    chk("midrst no done", dones_in(0, t + 1, t2), 0);
    check_frame("after midrst", 0, t2, d2, 434, 1'b0, 1'b0, 1);

    for (int r = 0; r < 4; r++) begin
      d = 8'($urandom);
      b = 3'($urandom_range(0, 5));
      if (b != 3'd0) b = b + 3'd2;
      step_to(cyc + longint'($urandom_range(0, 30)));
      if0.Data = d; if0.Baud_set = b; if0.send_en = 1'b1;
      t = cyc + 1;
      step_to(t);
      if0.send_en = 1'b0;
      if0.Data = 8'($urandom);
      if0.Baud_set = 3'($urandom);
      step_to(t + 10 * n_of(b) + 10);
      check_frame("random", 0, t, d, n_of(b), 1'b0, 1'b0, 1);
    end

    step_to(tp + 62497 + 10);
    check_frame("parity even", 1, tp, 8'h07, 5208, 1'b1, 1'b0, 1);
    chk("parity even bit", val_at(0, 1, tp + 1 + 9 * 5208 + 2604), 1);
    chk("parity even done offset", first_done_after(1, tp) - tp, 57289);
    check_frame("parity odd", 2, tp, 8'h07, 5208, 1'b1, 1'b1, 1);
    chk("parity odd bit", val_at(0, 2, tp + 1 + 9 * 5208 + 2604), 0);
    check_frame("two stop", 3, tp, 8'h07, 5208, 1'b1, 1'b0, 2);
    chk("two stop done offset", first_done_after(3, tp) - tp, 62497);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
